apb_request_arbiter: RTL and testbench

Two-requester front end for the APB master. It accepts single-transaction requests from two sources (e.g. CPU port 0, DMA port 1) and arbitrates between them round-robin. It drives the master's command inputs (transfer, Read_Write, PADDR_I, write_data) for one transaction at a time. It watches the bus handshake (PENABLE/PREADY/PRDATA) to detect completion, return read data and abort hung transfers on timeout.

---
 rtl/apb_request_arbiter_if.sv | 24 ++
 rtl/apb_request_arbiter.sv | 147 ++++++++++++++
 tb/tb_apb_request_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/apb_request_arbiter_if.sv
// Command and handshake bundle between the request arbiter and the APB master.
// The arbiter drives the command fields and observes the bus access phase.
interface apb_request_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              transfer;
    logic              Read_Write;
    logic [ADDR_W-1:0] PADDR_I;
    logic [DATA_W-1:0] write_data;
    logic              PENABLE;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        output transfer, Read_Write, PADDR_I, write_data,
        input  PENABLE, PREADY, PRDATA
    );

    modport slave (
        input  transfer, Read_Write, PADDR_I, write_data,
        output PENABLE, PREADY, PRDATA
    );
endinterface

// File: rtl/apb_request_arbiter.sv
// Two-port round-robin front end for the APB master: one transaction at a time,
// completion on PENABLE && PREADY, optional abort after TIMEOUT busy cycles.
module apb_request_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESTn,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    apb_request_arbiter_if.master bus
);
    // Keep the counter at least one bit wide so TIMEOUT = 0 still elaborates.
    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_owner_reg, last_owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              transfer_reg, transfer_next;
    logic              rw_reg, rw_next;
    logic [ADDR_W-1:0] paddr_reg, paddr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] rd_data_reg, rd_data_next;
    logic              gnt0_reg, gnt0_next, gnt1_reg, gnt1_next;
    logic              done0_reg, done0_next, done1_reg, done1_next;
    logic              err_reg, err_next;
    logic              pick1;

    // Port 1 wins when it is the only requester, or on a tie when port 0 went last.
    assign pick1 = req1 && (!req0 || !last_owner_reg);

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = cnt_reg;
        transfer_next   = transfer_reg;
        rw_next         = rw_reg;
        paddr_next      = paddr_reg;
        wdata_next      = wdata_reg;
        rd_data_next    = rd_data_reg;
        gnt0_next       = 1'b0;
        gnt1_next       = 1'b0;
        done0_next      = 1'b0;
        done1_next      = 1'b0;
        err_next        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    rw_next         = pick1 ? write1 : write0;
                    paddr_next      = pick1 ? addr1  : addr0;
                    wdata_next      = pick1 ? wdata1 : wdata0;
                    transfer_next   = 1'b1;
                    gnt0_next       = !pick1;
                    gnt1_next       = pick1;
                    owner_next      = pick1;
                    last_owner_next = pick1;
                    cnt_next        = '0;
                    state_next      = BUSY;
                end
            end
            BUSY: begin
                if (bus.PENABLE && bus.PREADY) begin
                    transfer_next = 1'b0;
                    done0_next    = !owner_reg;
                    done1_next    = owner_reg;
                    if (!rw_reg)
                        rd_data_next = bus.PRDATA;
                    state_next    = IDLE;
                end else if (TIMEOUT != 0 && cnt_reg == TMO_LAST) begin
                    transfer_next = 1'b0;
                    done0_next    = !owner_reg;
                    done1_next    = owner_reg;
                    err_next      = 1'b1;
                    rd_data_next  = '0;
                    state_next    = IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESTn) begin
        if (!PRESTn) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            cnt_reg        <= '0;
            transfer_reg   <= 1'b0;
            rw_reg         <= 1'b0;
            paddr_reg      <= '0;
            wdata_reg      <= '0;
            rd_data_reg    <= '0;
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
            done0_reg      <= 1'b0;
            done1_reg      <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
            transfer_reg   <= transfer_next;
            rw_reg         <= rw_next;
            paddr_reg      <= paddr_next;
            wdata_reg      <= wdata_next;
            rd_data_reg    <= rd_data_next;
            gnt0_reg       <= gnt0_next;
            gnt1_reg       <= gnt1_next;
            done0_reg      <= done0_next;
            done1_reg      <= done1_next;
            err_reg        <= err_next;
        end
    end

    assign bus.transfer   = transfer_reg;
    assign bus.Read_Write = rw_reg;
    assign bus.PADDR_I    = paddr_reg;
    assign bus.write_data = wdata_reg;
    assign gnt0           = gnt0_reg;
    assign gnt1           = gnt1_reg;
    assign done0          = done0_reg;
    assign done1          = done1_reg;
    assign err            = err_reg;
    assign rd_data        = rd_data_reg;
endmodule

// File: tb/tb_apb_request_arbiter.sv
// Directed bench for apb_request_arbiter: reset, single read, tie, fairness,
// timeout (and TIMEOUT = 0 instance), completion-vs-timeout and reset mid-BUSY.
module tb_apb_request_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESTn = 1'b0;
    logic        rstn_nt = 1'b0;
    logic        req0 = 0, req1 = 0, write0 = 0, write1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
    logic        gnt0, gnt1, done0, done1, err;
    logic [31:0] rd_data;
    logic        nt_gnt0, nt_gnt1, nt_done0, nt_done1, nt_err;
    logic [31:0] nt_rd_data;
    int          total = 0;
    int          bad = 0;
    int          nt_done_cnt = 0;

    apb_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    apb_request_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_nt ();

    apb_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESTn(PRESTn),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
        .rd_data(rd_data), .bus(bus.master)
    );

    apb_request_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_nt (
        .PCLK(PCLK), .PRESTn(rstn_nt),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(nt_gnt0), .gnt1(nt_gnt1), .done0(nt_done0), .done1(nt_done1), .err(nt_err),
        .rd_data(nt_rd_data), .bus(bus_nt.master)
    );

    always #5 PCLK = ~PCLK;

    assign bus_nt.PENABLE = 1'b1;
    assign bus_nt.PREADY  = 1'b0;
    assign bus_nt.PRDATA  = 32'hDEADBEEF;

    always @(posedge PCLK)
        if (nt_done0 || nt_done1 || nt_err)
            nt_done_cnt <= nt_done_cnt + 1;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_bus(input logic en, input logic rdy, input logic [31:0] data);
        bus.PENABLE = en;
        bus.PREADY  = rdy;
        bus.PRDATA  = data;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, {bus.transfer, bus.Read_Write, bus.PADDR_I, gnt0, gnt1, done0, done1, err},
            '0);
        chk({tag, "_data"}, {bus.write_data, rd_data}, '0);
    endtask

    initial begin
        set_bus(0, 0, 0);
        // Power-on reset
        tick();
        chk_all_zero("reset_init");
        #2 PRESTn = 1'b1; rstn_nt = 1'b1;
        tick(); tick();
        chk("idle_no_req", bus.transfer, 0);

        // Single read from port 0
        req0 = 1; write0 = 0; addr0 = 32'h1000;
        tick();
        chk("rd_gnt", {gnt0, gnt1, bus.transfer}, 3'b101);
        chk("rd_cmd", {bus.Read_Write, bus.PADDR_I}, {1'b0, 32'h1000});
        req0 = 0; addr0 = 32'h5555;
        tick();
        chk("rd_gnt_pulse", {gnt0, done0, bus.transfer, bus.PADDR_I}, {3'b001, 32'h1000});
        set_bus(1, 1, 32'h0EC25F01);
        tick();
        chk("rd_done", {done0, done1, err, bus.transfer}, 4'b1000);
        chk("rd_data", rd_data, 32'h0EC25F01);
        set_bus(0, 0, 0);
        tick();
        chk("rd_done_pulse", {done0, bus.transfer, rd_data}, {2'b00, 32'h0EC25F01});

        // Asynchronous reset mid-cycle clears everything immediately
        #2 PRESTn = 1'b0;
        #1 chk_all_zero("reset_async");
        tick();
        #2 PRESTn = 1'b1;
        tick(); tick();
        chk("reset_idle", bus.transfer, 0);

        // Tie: port 0 first (last_owner = 1 after reset), then port 1
        req0 = 1; write0 = 1; addr0 = 32'h1004; wdata0 = 32'hF0FF00F0;
        req1 = 1; write1 = 0; addr1 = 32'h2000; wdata1 = 32'h0;
        tick();
        chk("tie_gnt0", {gnt0, gnt1, bus.transfer}, 3'b101);
        chk("tie_cmd0", {bus.Read_Write, bus.PADDR_I, bus.write_data}, {1'b1, 32'h1004, 32'hF0FF00F0});
        req0 = 0;
        set_bus(1, 1, 32'h77777777);
        tick();
        chk("tie_done0", {done0, done1, bus.transfer}, 3'b100);
        chk("tie_wr_keeps_rd", rd_data, 32'h0);
        set_bus(0, 0, 0);
        tick();
        chk("tie_gnt1", {gnt0, gnt1, done0, bus.transfer}, 4'b0101);
        chk("tie_cmd1", {bus.Read_Write, bus.PADDR_I}, {1'b0, 32'h2000});
        req1 = 0;
        set_bus(1, 1, 32'h12345678);
        tick();
        chk("tie_done1", {done0, done1, err, bus.transfer}, 4'b0100);
        chk("tie_rd1", rd_data, 32'h12345678);
        set_bus(0, 0, 0);
        tick();

        // Fairness: both held, bus always ready -> owners 0,1,0,1 (last_owner = 1)
        req0 = 1; req1 = 1; write0 = 0; write1 = 0;
        set_bus(1, 1, 32'hA5A5A5A5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("fair_gnt%0d", i), {gnt0, gnt1, bus.transfer},
                (i % 2 == 0) ? 3'b101 : 3'b011);
            tick();
            chk($sformatf("fair_done%0d", i), {done0, done1, bus.transfer},
                (i % 2 == 0) ? 3'b100 : 3'b010);
        end
        req0 = 0; req1 = 0;
        set_bus(0, 0, 0);
        chk("fair_rd", rd_data, 32'hA5A5A5A5);
        tick();

        // Timeout on port 1: transfer high exactly 16 cycles
        req1 = 1; write1 = 0; addr1 = 32'h3000;
        set_bus(0, 0, 32'h99999999);
        tick();
        chk("tmo_gnt1", {gnt1, bus.transfer}, 2'b11);
        req1 = 0;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk($sformatf("tmo_busy%0d", i), {bus.transfer, done1, err}, 3'b100);
        end
        tick();
        chk("tmo_abort", {done0, done1, err, bus.transfer}, 4'b0110);
        chk("tmo_rd_clear", rd_data, 32'h0);
        tick();
        chk("tmo_err_pulse", {done1, err}, 2'b00);

        // Completion on the same edge as timeout: completion wins
        req0 = 1; write0 = 0; addr0 = 32'h4000;
        tick();
        chk("race_gnt0", {gnt0, bus.transfer}, 2'b11);
        req0 = 0;
        for (int i = 1; i < 16; i++) tick();
        chk("race_busy", bus.transfer, 1);
        set_bus(1, 1, 32'hCAFEF00D);
        tick();
        chk("race_done", {done0, err, bus.transfer}, 3'b100);
        chk("race_rd", rd_data, 32'hCAFEF00D);
        set_bus(0, 0, 0);
        tick();

        // Port 1 read interrupted by reset; afterwards port 0 wins the tie
        req1 = 1; write1 = 0; addr1 = 32'h5000;
        tick();
        chk("rst_busy_gnt1", {gnt1, bus.transfer}, 2'b11);
        req1 = 0;
        tick();
        #2 PRESTn = 1'b0;
        #1 chk_all_zero("rst_busy_async");
        tick();
        chk("rst_busy_nodone", {done1, bus.transfer}, 2'b00);
        tick();
        #2 PRESTn = 1'b1;
        req0 = 1; req1 = 1;
        tick();
        chk("rst_busy_tie", {gnt0, gnt1, done1}, 3'b100);
        req0 = 0; req1 = 0;
        set_bus(1, 1, 0);
        tick();
        chk("rst_busy_done0", {done0, done1}, 2'b10);
        set_bus(0, 0, 0);
        tick();

        // TIMEOUT = 0 instance: granted early, never completes, never aborts
        chk("nt_transfer_held", bus_nt.transfer, 1);
        chk("nt_no_done", nt_done_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
